fp_align_shifter: RTL

//  Multi-cycle operand alignment stage for the floating-point adder datapath.
//  - Accepts two operands (exponent, mantissa with hidden bit) and compares the exponents.
//  - Swaps the operands so the larger exponent comes first.
//  - Right-shifts the smaller mantissa by the exponent difference, with guard/round/sticky retention.
//  - Generalises the former combinational alignment: parametrised widths, per-cycle shift step,
//    GRS bits, automatic swap, saturation and valid/ready handshakes on both sides.

---
 rtl/fp_pkg.sv | 20 ++
 rtl/fp_sticky_shr.sv | 27 ++
 rtl/fp_align_shifter.sv | 130 +++++++++++++
 3 files changed

// File: rtl/fp_pkg.sv
`default_nettype none
// ============================================================================
// Module : fp_pkg
// Brief  : Shared constants and FSM encoding for the floating-point datapath
// Rev    : 1.0  initial release
// ============================================================================
package fp_pkg;

    localparam int c_FP_EXP_W = 5;
    localparam int c_FP_MAN_W = 11;
    localparam int c_GRS_W    = 3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

endpackage
`default_nettype wire

// File: rtl/fp_sticky_shr.sv
`default_nettype none
// ============================================================================
// Module : fp_sticky_shr
// Brief  : Right shift of {mantissa,G,R,S}; shifted-out bits are ORed into S
// Rev    : 1.0  initial release
// ============================================================================
module fp_sticky_shr #(
    parameter int W    = 14,
    parameter int SH_W = 5
) (
    input  logic [W-1:0]    i_data,
    input  logic [SH_W-1:0] i_shamt,
    output logic [W-1:0]    o_data
);

    logic [W-1:0] w_mask;
    logic [W-1:0] w_shr;
    logic         w_lost;

    // Mask covers exactly the bits that fall off position 0, including the old S.
    assign w_mask = ~({W{1'b1}} << i_shamt);
    assign w_lost = |(i_data & w_mask);
    assign w_shr  = i_data >> i_shamt;
    assign o_data = {w_shr[W-1:1], w_shr[0] | w_lost};

endmodule
`default_nettype wire

// File: rtl/fp_align_shifter.sv
`default_nettype none
// ============================================================================
// Module : fp_align_shifter
// Brief  : Multi-cycle exponent compare, swap and sticky right-shift alignment
// Rev    : 1.0  initial release
// ============================================================================
module fp_align_shifter
    import fp_pkg::*;
#(
    parameter int EXP_W      = c_FP_EXP_W,
    parameter int MAN_W      = c_FP_MAN_W,
    parameter int SHIFT_STEP = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [EXP_W-1:0]         exp_a,
    input  logic [EXP_W-1:0]         exp_b,
    input  logic [MAN_W-1:0]         man_a,
    input  logic [MAN_W-1:0]         man_b,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [EXP_W-1:0]         exp_out,
    output logic [MAN_W-1:0]         man_big,
    output logic [MAN_W+c_GRS_W-1:0] man_small,
    output logic                     swapped
);

    localparam int                 c_SW   = MAN_W + c_GRS_W;
    localparam logic [EXP_W:0]     c_SAT  = (EXP_W+1)'(MAN_W + 2);
    localparam logic [EXP_W-1:0]   c_STEP = EXP_W'(SHIFT_STEP);

    state_t             r_state;
    logic               r_in_ready;
    logic               r_out_valid;
    logic [EXP_W-1:0]   r_exp_out;
    logic [MAN_W-1:0]   r_man_big;
    logic [c_SW-1:0]    r_man_small;
    logic               r_swapped;
    logic [EXP_W-1:0]   r_rem;

    logic               w_swap;
    logic [EXP_W-1:0]   w_diff;
    logic [MAN_W-1:0]   w_big_man;
    logic [MAN_W-1:0]   w_sml_man;
    logic [EXP_W-1:0]   w_k;
    logic [c_SW-1:0]    w_shifted;

    assign w_swap    = (exp_b > exp_a);
    assign w_diff    = w_swap ? (exp_b - exp_a) : (exp_a - exp_b);
    assign w_big_man = w_swap ? man_b : man_a;
    assign w_sml_man = w_swap ? man_a : man_b;
    assign w_k       = (r_rem < c_STEP) ? r_rem : c_STEP;

    fp_sticky_shr #(
        .W    (c_SW),
        .SH_W (EXP_W)
    ) u_shr (
        .i_data  (r_man_small),
        .i_shamt (w_k),
        .o_data  (w_shifted)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_exp_out   <= '0;
            r_man_big   <= '0;
            r_man_small <= '0;
            r_swapped   <= 1'b0;
            r_rem       <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (in_valid) begin
                        r_exp_out   <= w_swap ? exp_b : exp_a;
                        r_man_big   <= w_big_man;
                        r_swapped   <= w_swap;
                        r_in_ready  <= 1'b0;
                        r_man_small <= {w_sml_man, {c_GRS_W{1'b0}}};
                        if (w_diff == '0) begin
                            r_state     <= ST_DONE;
                            r_out_valid <= 1'b1;
                        end else if ({1'b0, w_diff} >= c_SAT) begin
                            // Everything falls below S: only "was it nonzero" survives.
                            r_man_small <= {{(MAN_W+2){1'b0}}, |w_sml_man};
                            r_state     <= ST_DONE;
                            r_out_valid <= 1'b1;
                        end else begin
                            r_rem   <= w_diff;
                            r_state <= ST_SHIFT;
                        end
                    end
                end
                ST_SHIFT: begin
                    r_man_small <= w_shifted;
                    r_rem       <= r_rem - w_k;
                    if (r_rem == w_k) begin
                        r_state     <= ST_DONE;
                        r_out_valid <= 1'b1;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        r_state     <= ST_IDLE;
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                    end
                end
                default: begin
                    r_state     <= ST_IDLE;
                    r_in_ready  <= 1'b1;
                    r_out_valid <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign exp_out   = r_exp_out;
    assign man_big   = r_man_big;
    assign man_small = r_man_small;
    assign swapped   = r_swapped;

endmodule
`default_nettype wire
